accum_seq: RTL and testbench

ACCUM_SEQ -- requirements
Module: accum_seq

---
 rtl/accum_seq.sv | 115 +++++++++++
 tb/tb_accum_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq.sv
// Sequential accumulator: sums NSAMP 4-bit operands through an external adder and presents the
// wrapped result with a sticky overflow flag behind a valid/ready handshake.
module accum_seq #(
   parameter int unsigned NSAMP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic [3:0] add_m,
   output logic [3:0] add_n,
   input  logic [3:0] add_z,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] result,
   output logic       ovf,
   output logic       busy
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [3:0] LastCnt = 4'(NSAMP - 1);

   state_e     state_q, state_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ovf_q, ovf_d;
   logic       start_run;
   logic       beat;
   logic       last_beat;

   assign start_run = (state_q == StIdle) && start;
   assign beat      = (state_q == StRun) && in_valid;
   assign last_beat = beat && (cnt_q == LastCnt);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start)     state_d = StRun;
         StRun:  if (last_beat) state_d = StDone;
         StDone: if (out_ready) state_d = StIdle;
         default:               state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle: ;
         StRun: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         StDone: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: the accumulator only ever loads zero or the adder's sum
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (start_run) begin
         acc_d = 4'd0;
         cnt_d = 4'd0;
         ovf_d = 1'b0;
      end else if (beat) begin
         acc_d = add_z;
         cnt_d = cnt_q + 4'd1;
         // A sum smaller than the old accumulator means bit 3 carried out
         ovf_d = ovf_q | (add_z < acc_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= 4'd0;
         cnt_q <= 4'd0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign add_m  = acc_q;
   assign add_n  = in_data;
   assign result = acc_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_accum_seq.sv
// Self-checking bench for accum_seq: table-driven runs, hand-written reset/stall sequences and
// random runs checked against a sum-based reference model.
module tb_accum_seq;

   localparam int unsigned NSAMP = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic [3:0] add_m;
   logic [3:0] add_n;
   logic [3:0] add_z;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       ovf;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   accum_seq #(.NSAMP(NSAMP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .add_m     (add_m),
      .add_n     (add_n),
      .add_z     (add_z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .busy      (busy)
   );

   // External adder model
   assign add_z = 4'((int'(add_m) + int'(add_n)) % 16);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] ops;   // first operand in the low nibble
      logic [3:0]  res;
      logic        ovf;
      logic [3:0]  gap;
      logic [3:0]  bp;
      logic        poke;
   } vec_t;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, ".state_idle_busy"}, int'(busy), 0);
      check({nm, ".in_ready"}, int'(in_ready), 0);
      check({nm, ".out_valid"}, int'(out_valid), 0);
      check({nm, ".result"}, int'(result), 0);
      check({nm, ".ovf"}, int'(ovf), 0);
      check({nm, ".add_m"}, int'(add_m), 0);
   endtask

   // One complete run; the model tracks the integer sum, result is sum mod 16 and overflow is
   // simply whether the running sum has ever reached 16.
   task automatic do_run(input string nm, input logic [15:0] ops, input int gap, input int bp,
                         input bit poke, input int exp_res, input int exp_ovf);
      int sum;
      int op;
      sum = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, ".rdy_after_start"}, int'(in_ready), 1);
      check({nm, ".busy_after_start"}, int'(busy), 1);
      check({nm, ".result_cleared"}, int'(result), 0);
      check({nm, ".ovf_cleared"}, int'(ovf), 0);
      for (int i = 0; i < int'(NSAMP); i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom_range(15, 0));
            #1;
            check({nm, ".stall_add_m"}, int'(add_m), sum % 16);
            check({nm, ".stall_add_n"}, int'(add_n), int'(in_data));
            check({nm, ".stall_rdy"}, int'(in_ready), 1);
            tick();
            check({nm, ".stall_result"}, int'(result), sum % 16);
         end
         op       = int'(ops[i*4 +: 4]);
         in_valid = 1'b1;
         in_data  = 4'(op);
         start    = poke && (i == 1);
         #1;
         check({nm, ".beat_add_m"}, int'(add_m), sum % 16);
         check({nm, ".beat_add_n"}, int'(add_n), op);
         tick();
         in_valid = 1'b0;
         start    = 1'b0;
         sum += op;
         check({nm, ".beat_result"}, int'(result), sum % 16);
         check({nm, ".beat_ovf"}, int'(ovf), int'(sum >= 16));
         check({nm, ".beat_out_valid"}, int'(out_valid), int'(i == int'(NSAMP) - 1));
      end
      check({nm, ".result"}, int'(result), exp_res);
      check({nm, ".ovf"}, int'(ovf), exp_ovf);
      for (int b = 0; b < bp; b++) begin
         out_ready = 1'b0;
         start     = poke && (b == 0);
         in_valid  = 1'b1;
         in_data   = 4'($urandom_range(15, 0));
         tick();
         check({nm, ".bp_out_valid"}, int'(out_valid), 1);
         check({nm, ".bp_in_ready"}, int'(in_ready), 0);
         check({nm, ".bp_result"}, int'(result), exp_res);
         check({nm, ".bp_ovf"}, int'(ovf), exp_ovf);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, ".idle_out_valid"}, int'(out_valid), 0);
      check({nm, ".idle_busy"}, int'(busy), 0);
      check({nm, ".idle_in_ready"}, int'(in_ready), 0);
      check({nm, ".idle_result_kept"}, int'(result), exp_res);
      check({nm, ".idle_ovf_kept"}, int'(ovf), exp_ovf);
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{ops: 16'h4321, res: 4'd10, ovf: 1'b0, gap: 4'd0, bp: 4'd0, poke: 1'b0};
      vecs[1] = '{ops: 16'h1089, res: 4'd2,  ovf: 1'b1, gap: 4'd0, bp: 4'd1, poke: 1'b0};
      vecs[2] = '{ops: 16'h0000, res: 4'd0,  ovf: 1'b0, gap: 4'd1, bp: 4'd0, poke: 1'b0};
      vecs[3] = '{ops: 16'hFFFF, res: 4'd12, ovf: 1'b1, gap: 4'd0, bp: 4'd2, poke: 1'b0};
      vecs[4] = '{ops: 16'h0078, res: 4'd15, ovf: 1'b0, gap: 4'd0, bp: 4'd0, poke: 1'b0};
      vecs[5] = '{ops: 16'h0187, res: 4'd0,  ovf: 1'b1, gap: 4'd3, bp: 4'd5, poke: 1'b0};
      vecs[6] = '{ops: 16'h2345, res: 4'd14, ovf: 1'b0, gap: 4'd0, bp: 4'd2, poke: 1'b1};

      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;
      #1;
      check_all_zero("reset_async");
      #20;
      rst_n = 1'b1;
      tick();
      check_all_zero("reset_release");

      for (int k = 0; k < 7; k++) begin
         do_run($sformatf("vec%0d", k), vecs[k].ops, int'(vecs[k].gap), int'(vecs[k].bp),
                vecs[k].poke, int'(vecs[k].res), int'(vecs[k].ovf));
      end

      // Mid-run reset: two beats, then an asynchronous abort between clock edges
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'd9;
      tick();
      in_data = 4'd9;
      tick();
      check("midrst.pre_ovf", int'(ovf), 1);
      check("midrst.pre_result", int'(result), 2);
      #2;
      rst_n = 1'b0;
      #1;
      in_valid = 1'b0;
      check_all_zero("midrst_async");
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      check_all_zero("midrst_idle");
      do_run("midrst_after", 16'h001F, 0, 1, 1'b0, 0, 1);

      // Random runs against the sum model
      for (int r = 0; r < 25; r++) begin
         logic [15:0] ops;
         int          sum;
         ops = 16'($urandom());
         sum = 0;
         for (int i = 0; i < int'(NSAMP); i++) sum += int'(ops[i*4 +: 4]);
         do_run($sformatf("rnd%0d", r), ops, int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), bit'($urandom_range(1, 0)), sum % 16,
                int'(sum >= 16));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
